lfsr_crypt_engine: RTL and testbench

Hardware LFSR stream-cipher engine that replaces the software Program #1 loop. It is the parametrised successor of the 7-bit, 64-byte encryption flow, and it adds a decrypt mode. It reads its config (pre_length, taps, seed) and message from the shared data memory, then writes a MSG_LEN-byte result block. It sits beside the CPU core on the data-memory port and uses the same req/ack launch protocol as top_level.

---
 rtl/lfsr_crypt_engine_if.sv | 36 +++
 rtl/lfsr_crypt_engine.sv | 192 +++++++++++++++++++
 tb/tb_lfsr_crypt_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_crypt_engine_if.sv
// lfsr_crypt_engine_if
//   Launch handshake and data-memory port of the LFSR stream-cipher engine.
//   master : the engine (drives ack/busy and the memory address/write side)
//   slave  : the host CPU plus data memory (drives req/mode and read data)
//   Signals:
//     req          launch request, run starts on its high->low transition
//     mode         0 = encrypt, 1 = decrypt, sampled at launch
//     ack          run complete, held until req returns high
//     busy         high from launch until ack
//     mem_addr     memory address
//     mem_rd_data  read data, valid one cycle after the address
//     mem_wr_en    write strobe
//     mem_wr_data  write data
interface lfsr_crypt_engine_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              req;
   logic              mode;
   logic              ack;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              mem_wr_en;
   logic [DATA_W-1:0] mem_wr_data;

   modport master (
      input  req, mode, mem_rd_data,
      output ack, busy, mem_addr, mem_wr_en, mem_wr_data
   );

   modport slave (
      output req, mode, mem_rd_data,
      input  ack, busy, mem_addr, mem_wr_en, mem_wr_data
   );
endinterface

// File: rtl/lfsr_crypt_engine.sv
// lfsr_crypt_engine
//   LFSR stream-cipher engine on the shared data-memory port. On a req
//   high->low it reads pre_length/taps/seed from CFG_BASE..CFG_BASE+2, then
//   for each of MSG_LEN bytes performs one read cycle and one write cycle,
//   XOR-ing the data with the LFSR state. Encrypt prepends pre_length zero
//   (biased space) bytes; decrypt drops them and zero-fills the tail.
//   Ports:
//     clk     system clock, rising edge
//     init_n  asynchronous active-low reset
//     bus     lfsr_crypt_engine_if.master (req, mode, ack, busy, mem_*)
//   Build option:
//     PARITY_EN  when defined, bit LFSR_W of each encrypt write carries the
//                even parity of the ciphertext bits; otherwise it is 0.
module lfsr_crypt_engine #(
   parameter int LFSR_W   = 7,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int MSG_LEN  = 64,
   parameter int SRC_BASE = 0,
   parameter int SRC_LEN  = 61,
   parameter int CFG_BASE = 61,
   parameter int DST_BASE = 64
) (
   input  logic                clk,
   input  logic                init_n,
   lfsr_crypt_engine_if.master bus
);

   localparam int                CNT_W     = $clog2(MSG_LEN + 1);
   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(MSG_LEN - 1);
   localparam logic [CNT_W-1:0]  MSG_LEN_C = CNT_W'(MSG_LEN);
   localparam logic [ADDR_W-1:0] SRC_A     = ADDR_W'(SRC_BASE);
   localparam logic [ADDR_W-1:0] DST_A     = ADDR_W'(DST_BASE);
   localparam logic [ADDR_W-1:0] CFG_A     = ADDR_W'(CFG_BASE);
   localparam logic [31:0]       SRC_LEN_U = 32'(SRC_LEN);
   localparam logic [31:0]       MSG_LEN_U = 32'(MSG_LEN);

   // FIN is the single settling cycle between the last write and ack.
   typedef enum logic [2:0] {S_IDLE, S_CFG, S_RD, S_WR, S_FIN, S_DONE} state_t;

   state_t             state_q, state_nx;
   logic               req_d;
   logic               mode_q;
   logic [1:0]         cfg_cnt_q;
   logic [CNT_W-1:0]   idx_q;
   logic [CNT_W-1:0]   pre_q;
   logic [LFSR_W-1:0]  taps_q;
   logic [LFSR_W-1:0]  lfsr_q;

   logic [ADDR_W-1:0]  addr_c;
   logic               wr_en_c;
   logic [DATA_W-1:0]  wr_data_c;
   logic               busy_c;
   logic               ack_c;

   logic               in_msg;
   logic [CNT_W-1:0]   rel;
   logic               src_hit;

   function automatic logic [DATA_W-1:0] enc_byte(input logic [DATA_W-1:0] plain,
                                                  input logic [LFSR_W-1:0] ks);
      logic [LFSR_W-1:0] c;
      logic [DATA_W-1:0] w;
      c = plain[LFSR_W-1:0] ^ ks;
      w = DATA_W'(c);
`ifdef PARITY_EN
      w[LFSR_W] = ^c;
`endif
      return w;
   endfunction

   // The parity bit of the ciphertext is never fed into the plaintext.
   function automatic logic [DATA_W-1:0] dec_byte(input logic [DATA_W-1:0] rd,
                                                  input logic [LFSR_W-1:0] ks);
      return DATA_W'(rd[LFSR_W-1:0] ^ ks);
   endfunction

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                   input logic [LFSR_W-1:0] t);
      return {s[LFSR_W-2:0], ^(s & t)};
   endfunction

   function automatic logic [CNT_W-1:0] clamp_pre(input logic [DATA_W-1:0] raw);
      if (32'(raw) > MSG_LEN_U) return MSG_LEN_C;
      return CNT_W'(raw);
   endfunction

   // idx_q is stable across the RD/WR pair of a byte, so the source window
   // test is recomputed in WR instead of being carried in a flag.
   assign in_msg  = (idx_q >= pre_q);
   assign rel     = idx_q - pre_q;
   assign src_hit = in_msg && (32'(rel) < SRC_LEN_U);

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) state_q <= S_IDLE;
      else         state_q <= state_nx;
   end

   always_comb begin
      state_nx  = state_q;
      addr_c    = '0;
      wr_en_c   = 1'b0;
      wr_data_c = '0;
      busy_c    = 1'b0;
      ack_c     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_d && !bus.req) state_nx = S_CFG;
         end
         S_CFG: begin
            busy_c = 1'b1;
            if (cfg_cnt_q != 2'd3) addr_c = CFG_A + ADDR_W'(cfg_cnt_q);
            else                   state_nx = S_RD;
         end
         S_RD: begin
            busy_c   = 1'b1;
            state_nx = S_WR;
            if (mode_q)      addr_c = SRC_A + ADDR_W'(idx_q);
            else if (in_msg) addr_c = SRC_A + ADDR_W'(rel);
         end
         S_WR: begin
            busy_c   = 1'b1;
            wr_en_c  = 1'b1;
            state_nx = (idx_q == LAST_IDX) ? S_FIN : S_RD;
            if (!mode_q) begin
               addr_c    = DST_A + ADDR_W'(idx_q);
               wr_data_c = enc_byte(src_hit ? bus.mem_rd_data : '0, lfsr_q);
            end else if (in_msg) begin
               addr_c    = DST_A + ADDR_W'(rel);
               wr_data_c = dec_byte(bus.mem_rd_data, lfsr_q);
            end else begin
               // Discarded preamble slot is reused to zero one tail byte.
               addr_c = DST_A + ADDR_W'(MSG_LEN_C - pre_q + idx_q);
            end
         end
         S_FIN: begin
            busy_c   = 1'b1;
            state_nx = S_DONE;
         end
         S_DONE: begin
            ack_c = 1'b1;
            if (bus.req) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         req_d     <= 1'b0;
         mode_q    <= 1'b0;
         cfg_cnt_q <= '0;
         idx_q     <= '0;
         pre_q     <= '0;
         taps_q    <= '0;
         lfsr_q    <= '0;
      end else begin
         req_d <= bus.req;
         case (state_q)
            S_IDLE: begin
               if (state_nx == S_CFG) begin
                  mode_q    <= bus.mode;
                  cfg_cnt_q <= '0;
                  idx_q     <= '0;
               end
            end
            S_CFG: begin
               cfg_cnt_q <= cfg_cnt_q + 2'd1;
               case (cfg_cnt_q)
                  2'd1: pre_q  <= clamp_pre(bus.mem_rd_data);
                  2'd2: taps_q <= bus.mem_rd_data[LFSR_W-1:0];
                  2'd3: lfsr_q <= (bus.mem_rd_data[LFSR_W-1:0] == '0) ? LFSR_W'(1)
                                                                       : bus.mem_rd_data[LFSR_W-1:0];
                  default: ;
               endcase
            end
            S_WR: begin
               lfsr_q <= lfsr_step(lfsr_q, taps_q);
               idx_q  <= idx_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_addr    = addr_c;
   assign bus.mem_wr_en   = wr_en_c;
   assign bus.mem_wr_data = wr_data_c;
   assign bus.busy        = busy_c;
   assign bus.ack         = ack_c;

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// tb_lfsr_crypt_engine
//   Bench for lfsr_crypt_engine: shared memory model, golden vectors,
//   decrypt round trip, clamping, randomized configs and mid-run reset.
module tb_lfsr_crypt_engine;
   localparam int DW = 8, AW = 8, ML = 64, SRC_LEN = 61, CFG = 61, DST = 64;
`ifdef PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic init_n;
   logic load;
   always #5 clk = ~clk;

   lfsr_crypt_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   lfsr_crypt_engine dut (.clk(clk), .init_n(init_n), .bus(bus));

   logic [7:0] mem  [256];
   logic [7:0] img  [256];
   logic [7:0] expd [ML];
   logic [7:0] ciph [ML];
   int n_chk = 0;
   int n_bad = 0;
   string msg = "Mr. Watson, come here. I want to see you.";

   always @(posedge clk) begin
      if (load) mem <= img;
      else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
      bus.mem_rd_data <= mem[bus.mem_addr];
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load_mem();
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic set_cfg(input int pre, input int taps, input int seed);
      img[CFG]   = 8'(pre);
      img[CFG+1] = 8'(taps);
      img[CFG+2] = 8'(seed);
      for (int i = 0; i < ML; i++) img[DST+i] = 8'hEE;
   endtask

   // Expected destination block from the cipher rules applied to img.
   task automatic model(input bit m);
      int pre, taps, s, plain, c;
      int ks [ML];
      pre  = int'(img[CFG]);
      if (pre > ML) pre = ML;
      taps = int'(img[CFG+1]) & 'h7F;
      s    = int'(img[CFG+2]) & 'h7F;
      if (s == 0) s = 1;
      for (int i = 0; i < ML; i++) begin
         ks[i] = s;
         s = ((s << 1) & 'h7F) | ($countones(s & taps) % 2);
      end
      for (int i = 0; i < ML; i++) expd[i] = 8'h00;
      for (int i = 0; i < ML; i++) begin
         if (!m) begin
            plain = (i < pre || (i - pre) >= SRC_LEN) ? 0 : int'(img[i-pre]);
            c = (plain ^ ks[i]) & 'h7F;
            if (PAR && ($countones(c) % 2 == 1)) c = c | 'h80;
            expd[i] = 8'(c);
         end else if (i >= pre) begin
            expd[i-pre] = 8'((int'(img[i]) ^ ks[i]) & 'h7F);
         end
      end
   endtask

   task automatic check_dst(input string tag, input int lo, input int hi);
      for (int i = lo; i < hi; i++)
         chk_eq($sformatf("%s_dst%0d", tag, i), 32'(mem[DST+i]), 32'(expd[i]));
   endtask

   task automatic run(input string tag, input bit m, input int abort_at);
      int lat, wr_cnt, sched_bad, busy_bad;
      bit aborted;
      lat = -1; wr_cnt = 0; sched_bad = 0; busy_bad = 0; aborted = 1'b0;
      bus.req = 1'b1;
      repeat (2) @(negedge clk);
      bus.mode = m;
      bus.req  = 1'b0;
      for (int k = 0; k < 300 && lat < 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 2)  bus.mode = ~m;
         if (k == 20) bus.req = 1'b1;
         if (k == 22) bus.req = 1'b0;
         if (k == abort_at) begin
            chk_eq({tag, "_wr_en_pre_abort"}, 32'(bus.mem_wr_en), 32'd1);
            init_n = 1'b0;
            #1;
            chk_eq({tag, "_abort_wr_en"}, 32'(bus.mem_wr_en), 32'd0);
            chk_eq({tag, "_abort_ack"}, 32'(bus.ack), 32'd0);
            chk_eq({tag, "_abort_busy"}, 32'(bus.busy), 32'd0);
            chk_eq({tag, "_abort_addr"}, 32'(bus.mem_addr), 32'd0);
            chk_eq({tag, "_abort_wdata"}, 32'(bus.mem_wr_data), 32'd0);
            aborted = 1'b1;
            break;
         end
         if (bus.mem_wr_en) begin
            wr_cnt++;
            if (k < 5 || k > 131 || ((k - 5) % 2) != 0) sched_bad++;
         end
         if (bus.busy !== (k < 133)) busy_bad++;
         if (bus.ack === 1'b1) lat = k;
      end
      if (!aborted) begin
         chk_eq({tag, "_latency"}, 32'(lat), 32'd133);
         chk_eq({tag, "_wr_count"}, 32'(wr_cnt), 32'd64);
         chk_eq({tag, "_wr_sched"}, 32'(sched_bad), 32'd0);
         chk_eq({tag, "_busy"}, 32'(busy_bad), 32'd0);
         repeat (3) begin
            @(negedge clk);
            chk_eq({tag, "_ack_hold"}, 32'(bus.ack), 32'd1);
            chk_eq({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
         end
         bus.req = 1'b1;
         @(negedge clk);
         chk_eq({tag, "_ack_drop"}, 32'(bus.ack), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      init_n   = 1'b0;
      load     = 1'b0;
      bus.req  = 1'b1;
      bus.mode = 1'b0;
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk_eq("rst_ack", 32'(bus.ack), 32'd0);
      chk_eq("rst_busy", 32'(bus.busy), 32'd0);
      chk_eq("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
      chk_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
      chk_eq("rst_wdata", 32'(bus.mem_wr_data), 32'd0);
      init_n = 1'b1;
      @(negedge clk);

      // Golden vector
      for (int i = 0; i < SRC_LEN; i++) img[i] = (i < msg.len()) ? 8'(msg[i] - 8'h20) : 8'h00;
      set_cfg(10, 'h60, 'h01);
      model(1'b0);
      for (int i = 0; i < ML; i++) ciph[i] = expd[i];
      load_mem();
      run("gold", 1'b0, -1);
      chk_eq("gold_dst64", 32'(mem[DST]), PAR ? 32'h81 : 32'h01);
      chk_eq("gold_dst65", 32'(mem[DST+1]), PAR ? 32'h82 : 32'h02);
      check_dst("gold", 0, ML);

      // Zero seed behaves as seed 1
      set_cfg(12, 'h48, 'h01);
      model(1'b0);
      img[CFG+2] = 8'h00;
      load_mem();
      run("seed0", 1'b0, -1);
      chk_eq("seed0_byte0", 32'(mem[DST]), PAR ? 32'h81 : 32'h01);
      check_dst("seed0", 0, ML);

      // Decrypt round trip
      for (int i = 0; i < SRC_LEN; i++) img[i] = ciph[i];
      set_cfg(10, 'h60, 'h01);
      model(1'b1);
      load_mem();
      run("dec", 1'b1, -1);
      for (int i = 0; i < msg.len(); i++)
         chk_eq($sformatf("dec_plain%0d", i), 32'(mem[DST+i]), 32'(8'(msg[i] - 8'h20)));
      for (int i = msg.len(); i < 51; i++)
         chk_eq($sformatf("dec_zero%0d", i), 32'(mem[DST+i]), 32'd0);
      check_dst("dec", 0, ML);

      // Oversized preamble clamps to the block length
      for (int i = 0; i < SRC_LEN; i++) img[i] = 8'($urandom);
      set_cfg('h50, 'h60, 'h01);
      model(1'b0);
      load_mem();
      run("clamp", 1'b0, -1);
      chk_eq("clamp_byte0", 32'(mem[DST]), PAR ? 32'h81 : 32'h01);
      check_dst("clamp", 0, ML);

      // Randomized configurations and modes
      for (int r = 0; r < 5; r++) begin
         bit m;
         m = 1'($urandom_range(0, 1));
         for (int i = 0; i < SRC_LEN; i++) img[i] = 8'($urandom);
         set_cfg($urandom_range(0, 90), $urandom_range(0, 255), (r == 0) ? 0 : $urandom_range(0, 255));
         model(m);
         load_mem();
         run($sformatf("rnd%0d", r), m, -1);
         check_dst($sformatf("rnd%0d", r), 0, ML);
      end

      // Reset in the write cycle of byte 23, then a clean rerun
      for (int i = 0; i < SRC_LEN; i++) img[i] = (i < msg.len()) ? 8'(msg[i] - 8'h20) : 8'h00;
      set_cfg(10, 'h60, 'h01);
      model(1'b0);
      load_mem();
      run("abort", 1'b0, 51);
      repeat (2) @(negedge clk);
      check_dst("abort_done", 0, 23);
      for (int i = 23; i < ML; i++)
         chk_eq($sformatf("abort_untouched%0d", i), 32'(mem[DST+i]), 32'hEE);
      bus.req = 1'b1;
      repeat (2) @(negedge clk);
      init_n = 1'b1;
      @(negedge clk);
      load_mem();
      run("rerun", 1'b0, -1);
      check_dst("rerun", 0, ML);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
